// File: rtl/data_mem_stage.sv
// MEM stage of a 5-stage pipeline: 1024x32 data memory, branch/jump redirect,
// and a small FSM that stretches aligned loads over a registered read.
module data_mem_stage (
    input  logic        clk,
    input  logic        Reset,
    input  logic        RegWrite,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        Branch,
    input  logic        MemToReg,
    input  logic        Jump,
    input  logic        Zero,
    input  logic [31:0] PCAdder_SignExtension,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData2,
    input  logic [4:0]  Rd,
    output logic        PCSrc,
    output logic [31:0] BranchTarget,
    output logic        Stall,
    output logic        RegWriteOut,
    output logic        MemToRegOut,
    output logic [31:0] ReadDataOut,
    output logic [31:0] ALUResultOut,
    output logic [4:0]  RdOut,
    output logic        AlignErr
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

    state_t      state_reg;
    logic [31:0] mem [0:1023];
    logic [31:0] rd_data_reg;
    logic [9:0]  addr_reg;
    logic [31:0] alu_reg;
    logic [4:0]  rd_reg;
    logic        regwrite_reg;
    logic        memtoreg_reg;

    logic misaligned;
    logic store_go;
    logic load_go;

    assign misaligned = (MemRead | MemWrite) & (ALUResult[1:0] != 2'b00);
    // A combined read+write request is treated purely as a store.
    assign store_go   = (state_reg == IDLE) & MemWrite & ~misaligned & ~Reset;
    assign load_go    = (state_reg == IDLE) & MemRead & ~MemWrite & ~misaligned;

    assign PCSrc        = ~Reset & ((Branch & Zero) | Jump);
    assign BranchTarget = PCAdder_SignExtension;
    assign Stall        = ~Reset & (load_go | (state_reg == RD_WAIT));

    // Memory array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (store_go) begin
            mem[ALUResult[11:2]] <= ReadData2;
        end
        if (state_reg == RD_WAIT) begin
            rd_data_reg <= mem[addr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_reg    <= IDLE;
            RegWriteOut  <= 1'b0;
            MemToRegOut  <= 1'b0;
            ReadDataOut  <= 32'd0;
            ALUResultOut <= 32'd0;
            RdOut        <= 5'd0;
            AlignErr     <= 1'b0;
            addr_reg     <= 10'd0;
            alu_reg      <= 32'd0;
            rd_reg       <= 5'd0;
            regwrite_reg <= 1'b0;
            memtoreg_reg <= 1'b0;
        end else begin
            AlignErr <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load_go) begin
                        addr_reg     <= ALUResult[11:2];
                        alu_reg      <= ALUResult;
                        rd_reg       <= Rd;
                        regwrite_reg <= RegWrite;
                        memtoreg_reg <= MemToReg;
                        state_reg    <= RD_WAIT;
                    end else begin
                        RegWriteOut  <= RegWrite & ~misaligned;
                        MemToRegOut  <= MemToReg;
                        ALUResultOut <= ALUResult;
                        RdOut        <= Rd;
                        AlignErr     <= misaligned;
                    end
                end
                RD_WAIT: begin
                    state_reg <= RD_DONE;
                end
                RD_DONE: begin
                    RegWriteOut  <= regwrite_reg;
                    MemToRegOut  <= memtoreg_reg;
                    ALUResultOut <= alu_reg;
                    RdOut        <= rd_reg;
                    ReadDataOut  <= rd_data_reg;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_stage.sv
// Randomized scoreboard bench for data_mem_stage against a word-array reference model.
module tb_data_mem_stage;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        RegWrite = 0, MemWrite = 0, MemRead = 0, Branch = 0;
    logic        MemToReg = 0, Jump = 0, Zero = 0;
    logic [31:0] PCAdder_SignExtension = 0, ALUResult = 0, ReadData2 = 0;
    logic [4:0]  Rd = 0;
    logic        PCSrc, Stall, RegWriteOut, MemToRegOut, AlignErr;
    logic [31:0] BranchTarget, ReadDataOut, ALUResultOut;
    logic [4:0]  RdOut;

    data_mem_stage dut (
        .clk(clk), .Reset(Reset), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .MemRead(MemRead), .Branch(Branch), .MemToReg(MemToReg), .Jump(Jump),
        .Zero(Zero), .PCAdder_SignExtension(PCAdder_SignExtension),
        .ALUResult(ALUResult), .ReadData2(ReadData2), .Rd(Rd),
        .PCSrc(PCSrc), .BranchTarget(BranchTarget), .Stall(Stall),
        .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut),
        .ReadDataOut(ReadDataOut), .ALUResultOut(ALUResultOut),
        .RdOut(RdOut), .AlignErr(AlignErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        aerr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [0:1023];
    logic [31:0] last_rd = 32'd0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Drive one instruction, update the model, hold it while the DUT stalls.
    task automatic issue(input logic rw, input logic mw, input logic mr, input logic br,
                         input logic m2r, input logic jp, input logic z,
                         input logic [31:0] tgt, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
        exp_t e;
        logic mis, is_load;
        int   stall_cycles;
        @(negedge clk);
        Reset = 0;
        RegWrite = rw; MemWrite = mw; MemRead = mr; Branch = br; MemToReg = m2r;
        Jump = jp; Zero = z; PCAdder_SignExtension = tgt; ALUResult = addr;
        ReadData2 = wd; Rd = rd;
        mis     = (mr || mw) && (addr % 4 != 0);
        is_load = mr && !mw && !mis;
        e.m2r = m2r; e.alu = addr; e.rd = rd;
        if (is_load) begin
            last_rd = model_mem[(addr / 4) % 1024];
            e.rw = rw; e.aerr = 1'b0;
        end else begin
            if (mw && !mis) model_mem[(addr / 4) % 1024] = wd;
            e.rw = rw && !mis; e.aerr = mis;
        end
        e.rdata = last_rd;
        exp_q.push_back(e);
        #1;
        chk("pcsrc", {31'd0, PCSrc}, {31'd0, (br && z) || jp});
        chk("branch_target", BranchTarget, tgt);
        chk("stall_first", {31'd0, Stall}, {31'd0, is_load});
        stall_cycles = 0;
        while (Stall && stall_cycles < 10) begin
            stall_cycles++;
            @(negedge clk);
            #1;
        end
        if (is_load) chk("stall_cycles", stall_cycles, 2);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_stall"}, {31'd0, Stall}, 32'd0);
        chk({tag, "_regwrite"}, {31'd0, RegWriteOut}, 32'd0);
        chk({tag, "_memtoreg"}, {31'd0, MemToRegOut}, 32'd0);
        chk({tag, "_readdata"}, ReadDataOut, 32'd0);
        chk({tag, "_aluresult"}, ALUResultOut, 32'd0);
        chk({tag, "_rd"}, {27'd0, RdOut}, 32'd0);
        chk({tag, "_alignerr"}, {31'd0, AlignErr}, 32'd0);
    endtask

    // Reset for one edge, optionally with a store present that must be dropped.
    task automatic reset_cycle(input logic with_store, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        Reset = 1; MemWrite = with_store; MemRead = 0; RegWrite = 1; Jump = 1;
        Branch = 1; Zero = 1; ALUResult = addr; ReadData2 = wd; Rd = 5'd3;
        #1;
        chk("pcsrc_in_reset", {31'd0, PCSrc}, 32'd0);
        @(posedge clk);
        #1;
        check_zero_outputs("reset");
        last_rd = 32'd0;
    endtask

    // Accept a load, then reset while it sits in the read-wait state.
    task automatic abort_load(input logic [31:0] addr);
        @(negedge clk);
        Reset = 0; MemRead = 1; MemWrite = 0; RegWrite = 1; MemToReg = 1;
        Jump = 0; Branch = 0; ALUResult = addr; Rd = 5'd9;
        #1;
        chk("abort_stall_accept", {31'd0, Stall}, 32'd1);
        @(negedge clk);
        #1;
        chk("abort_stall_wait", {31'd0, Stall}, 32'd1);
        Reset = 1; MemRead = 0; RegWrite = 0; MemToReg = 0;
        @(posedge clk);
        #1;
        check_zero_outputs("abort");
        last_rd = 32'd0;
    endtask

    // Monitor: every edge taken with Stall low and Reset low is a MEM/WB capture.
    initial begin
        logic s, r;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            s = Stall;
            r = Reset;
            @(posedge clk);
            #1;
            if (!s && !r) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_capture: got capture expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk("regwrite_out", {31'd0, RegWriteOut}, {31'd0, e.rw});
                    chk("memtoreg_out", {31'd0, MemToRegOut}, {31'd0, e.m2r});
                    chk("readdata_out", ReadDataOut, e.rdata);
                    chk("aluresult_out", ALUResultOut, e.alu);
                    chk("rd_out", {27'd0, RdOut}, {27'd0, e.rd});
                    chk("alignerr", {31'd0, AlignErr}, {31'd0, e.aerr});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, idx, lo;
        logic [31:0] addr;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("init");
        // Prefill a 16-word pool so every load has known contents.
        for (int i = 0; i < 16; i++)
            issue(0, 1, 0, 0, 0, 0, 0, 32'd0, i * 4, $urandom, 5'd0);

        issue(0, 1, 0, 0, 0, 0, 0, 32'd0, 32'h10, 32'hDEADBEEF, 5'd0);
        issue(1, 0, 1, 0, 1, 0, 0, 32'd0, 32'h10, 32'd0, 5'd5);
        issue(0, 0, 0, 1, 0, 0, 1, 32'h40, 32'd0, 32'd0, 5'd1);
        issue(0, 0, 0, 1, 0, 0, 0, 32'h40, 32'd0, 32'd0, 5'd1);
        issue(0, 0, 0, 0, 0, 1, 0, 32'h80, 32'd0, 32'd0, 5'd1);
        issue(1, 0, 1, 0, 1, 0, 0, 32'd0, 32'h13, 32'd0, 5'd6);
        abort_load(32'h10);
        issue(1, 0, 1, 0, 1, 0, 0, 32'd0, 32'h10, 32'd0, 5'd7);
        issue(0, 1, 0, 0, 0, 0, 0, 32'd0, 32'h1004, 32'h1234, 5'd0);
        issue(1, 0, 1, 0, 1, 0, 0, 32'd0, 32'h4, 32'd0, 5'd8);
        issue(1, 1, 1, 0, 0, 0, 0, 32'd0, 32'h20, 32'd7, 5'd2);
        issue(1, 0, 1, 0, 1, 0, 0, 32'd0, 32'h20, 32'd0, 5'd2);
        issue(0, 1, 0, 0, 0, 0, 0, 32'd0, 32'h2A, 32'hBAD, 5'd0);
        issue(1, 0, 1, 0, 1, 0, 0, 32'd0, 32'h28, 32'd0, 5'd4);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 4);
            idx  = $urandom_range(0, 15);
            lo   = (kind == 4) ? $urandom_range(1, 3) : 0;
            addr = ($urandom & 32'hFFFF_F000) | (idx * 4) | lo;
            case (kind)
                0: issue($urandom, 1, 0, $urandom, $urandom, $urandom, $urandom, $urandom, addr, $urandom, $urandom);
                1: issue($urandom, 0, 1, $urandom, $urandom, $urandom, $urandom, $urandom, addr, $urandom, $urandom);
                2: issue($urandom, 0, 0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
                3: issue($urandom, 1, 1, $urandom, $urandom, $urandom, $urandom, $urandom, addr, $urandom, $urandom);
                default: issue($urandom, $urandom, 1, $urandom, $urandom, $urandom, $urandom, $urandom, addr, $urandom, $urandom);
            endcase
        end

        // A store present during reset must not reach memory.
        reset_cycle(1'b1, 32'h30, 32'h5555AAAA);
        issue(1, 0, 1, 0, 1, 0, 0, 32'd0, 32'h30, 32'd0, 5'd11);
        reset_cycle(1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        chk("queue_final", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_stage.md
DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Interface
REQ-001 SHALL have a single clock and a synchronous active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 RegWrite, MemWrite, MemRead, Branch, MemToReg, Jump, Zero  in  1 each  EX/MEM pipeline-register control outputs.
REQ-005 PCAdder_SignExtension  in  32  branch/jump target from EX/MEM.
REQ-006 ALUResult  in  32  byte address or ALU value from EX/MEM.
REQ-007 ReadData2  in  32  store data from EX/MEM.
REQ-008 Rd  in  5  destination register from EX/MEM.
REQ-009 PCSrc  out  1  redirect the PC to BranchTarget.
REQ-010 BranchTarget  out  32  redirect address.
REQ-011 Stall  out  1  hold all earlier stages this cycle.
REQ-012 RegWriteOut, MemToRegOut  out  1 each  MEM/WB control.
REQ-013 ReadDataOut, ALUResultOut  out  32 each  MEM/WB data.
REQ-014 RdOut  out  5  MEM/WB destination.
REQ-015 AlignErr  out  1  one-cycle pulse on a misaligned access.

Function
REQ-016 SHALL contain 1024x32 word memory, index = ALUResult[11:2]; ALUResult[31:12] ignored (address wraps).
REQ-017 PCSrc SHALL = (Branch & Zero) | Jump, combinational.
REQ-018 BranchTarget SHALL = PCAdder_SignExtension, combinational.
REQ-019 PCSrc SHALL be 0 while Reset is high.
REQ-020 FSM states SHALL be IDLE, RD_WAIT and RD_DONE; the reset state is IDLE.
REQ-021 In IDLE with a non-load or store, the MEM/WB registers SHALL capture on the same edge; latency is 1 cycle; Stall = 0.
REQ-022 A store SHALL write ReadData2 to the memory on the edge where it is accepted in IDLE (MemWrite=1 and aligned).
REQ-023 An aligned load (MemRead=1, MemWrite=0) in IDLE SHALL assert Stall combinationally, latch the address, Rd, RegWrite and MemToReg, and move to RD_WAIT.
REQ-024 RD_WAIT SHALL assert Stall, perform the memory read, and move to RD_DONE.
REQ-025 RD_DONE SHALL deassert Stall, load the MEM/WB registers with the read data and the latched controls, and return to IDLE; load latency is 3 edges with 2 stall cycles.
REQ-026 Inputs SHALL be ignored outside IDLE, because upstream is held by Stall.
REQ-027 MemRead=1 and MemWrite=1 together SHALL execute as a store only, with no stall.
REQ-028 When MemRead or MemWrite is set and ALUResult[1:0] != 0:
- no memory access;
- AlignErr=1 for one cycle;
- RegWriteOut captured as 0;
- no stall.
REQ-029 For non-load captures, ReadDataOut SHALL hold its previous value.
REQ-030 When RegWrite=0, the instruction SHALL still pass through with RegWriteOut=0.

Reset
REQ-031 Reset SHALL, on the next edge, from any state (including mid-load):
- set the FSM to IDLE;
- clear Stall, AlignErr, RegWriteOut, MemToRegOut, ReadDataOut, ALUResultOut and RdOut to 0;
- abort any pending load with no MEM/WB update.
REQ-032 Reset SHALL NOT clear memory contents.
REQ-033 Reset asserted with a store present SHALL suppress the write.

Verification
REQ-034 Store then load: MemWrite, ALUResult=0x10, ReadData2=0xDEADBEEF; then MemRead, MemToReg, RegWrite, Rd=5, addr 0x10 -> Stall high for 2 cycles, then ReadDataOut=0xDEADBEEF, RdOut=5, RegWriteOut=1.
REQ-035 Branch=1, Zero=1, PCAdder_SignExtension=0x40 -> PCSrc=1 and BranchTarget=0x40 in the same cycle; with Zero=0 -> PCSrc=0; Jump=1 alone -> PCSrc=1.
REQ-036 MemRead at ALUResult=0x13 -> AlignErr pulses 1 cycle, no Stall, RegWriteOut=0.
REQ-037 Load accepted, Reset asserted in RD_WAIT -> next edge: Stall=0, state IDLE, all outputs 0; a later read of the same address returns the previously stored data.
REQ-038 Wrap: store 0x1234 at ALUResult=0x1004 -> a load at 0x4 returns 0x1234.
REQ-039 MemRead=MemWrite=1, addr 0x20, ReadData2=7 -> no Stall; a subsequent load at 0x20 returns 7.
